// File: rtl/mem_arbiter_nch.sv
// mem_arbiter_nch: N-channel round-robin/fixed-priority arbiter for one memory port, with per-channel kill, drain and timeout.
module mem_arbiter_nch #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 240
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
    input  logic [NUM_REQ-1:0]          wen_i,
    input  logic [NUM_REQ-1:0]          kill_i,
    output logic [NUM_REQ-1:0]          ack_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        mem_req_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    output logic                        mem_wen_o,
    input  logic                        mem_ack_i,
    input  logic [DATA_W-1:0]           mem_rdata_i,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id_o,
    output logic                        busy_o,
    output logic                        timeout_o
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
    state_t state, state_n;
    logic [ID_W-1:0]    last, last_n, gid_n, win;
    logic [NUM_REQ-1:0] mask, mask_n, elig;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               req_n, wen_n, kill_g, done;
    logic [ADDR_W-1:0]  addr_n;
    logic [DATA_W-1:0]  wdata_n;
    function automatic logic [ID_W-1:0] slot(input logic [ID_W-1:0] l, input int i);
        return ID_W'((RR_MODE != 0) ? (int'(l) + 1 + i) % NUM_REQ : i);
    endfunction
    // Walk the search order backwards so the earliest eligible slot is written last.
    always_comb begin
        elig = req_i & ~mask;
        win  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (elig[slot(last, i)]) win = slot(last, i);
    end
    assign busy_o = state != IDLE;
    always_comb begin
        kill_g    = kill_i[grant_id_o];
        state_n   = state;
        last_n    = last;
        mask_n    = '0;
        cnt_n     = cnt;
        req_n     = mem_req_o;
        addr_n    = mem_addr_o;
        wdata_n   = mem_wdata_o;
        wen_n     = mem_wen_o;
        gid_n     = grant_id_o;
        ack_o     = '0;
        rdata_o   = '0;
        timeout_o = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (|elig) begin
                state_n = BUSY;
                req_n   = 1'b1;
                gid_n   = win;
                last_n  = win;
                addr_n  = addr_i[int'(win)*ADDR_W +: ADDR_W];
                wdata_n = wdata_i[int'(win)*DATA_W +: DATA_W];
                wen_n   = wen_i[win];
            end
            BUSY: if (kill_g && mem_ack_i) begin
                done = 1'b1;
            end else if (kill_g) begin
                state_n = DRAIN;
                cnt_n   = '0;
            end else if (mem_ack_i) begin
                done              = 1'b1;
                ack_o[grant_id_o] = 1'b1;
                rdata_o           = mem_rdata_i;
            end
            DRAIN: if (mem_ack_i) begin
                done = 1'b1;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                done      = 1'b1;
                timeout_o = 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // The served channel sits out the single IDLE cycle that follows.
        if (done) begin
            state_n            = IDLE;
            req_n              = 1'b0;
            mask_n[grant_id_o] = 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last        <= ID_W'(NUM_REQ - 1);
            mask        <= '0;
            cnt         <= '0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wen_o   <= 1'b0;
            grant_id_o  <= '0;
        end else begin
            state       <= state_n;
            last        <= last_n;
            mask        <= mask_n;
            cnt         <= cnt_n;
            mem_req_o   <= req_n;
            mem_addr_o  <= addr_n;
            mem_wdata_o <= wdata_n;
            mem_wen_o   <= wen_n;
            grant_id_o  <= gid_n;
        end
    end
endmodule

// File: tb/tb_mem_arbiter_nch.sv
// tb_mem_arbiter_nch: random traffic on a round-robin and a fixed-priority instance, checked cycle by cycle against a transaction model.
module tb_mem_arbiter_nch;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic [N-1:0]    req [2], wen [2], kill [2], ack [2];
    logic [N*AW-1:0] addr [2];
    logic [N*DW-1:0] wdata [2];
    logic            mack [2], mreq [2], mwen [2], busy [2], tmo [2];
    logic [DW-1:0]   mrdata [2], rdata [2], mwdata [2];
    logic [AW-1:0]   maddr [2];
    logic [1:0]      gid [2];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pa = 3;
    // Model: owner is the channel holding memory (-1 when free), blk the channel sitting out one idle cycle.
    int            owner [2], blk [2], last [2], dstart [2];
    bit            drn [2];
    logic          e_req [2], e_wen [2];
    logic [AW-1:0] e_addr [2];
    logic [DW-1:0] e_wdata [2];
    logic [1:0]    e_gid [2];
    logic [N-1:0]  want [2], e_ack [2];
    mem_arbiter_nch #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(TO)) u_rr (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
        .wen_i(wen[0]), .kill_i(kill[0]), .ack_o(ack[0]), .rdata_o(rdata[0]),
        .mem_req_o(mreq[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwdata[0]), .mem_wen_o(mwen[0]),
        .mem_ack_i(mack[0]), .mem_rdata_i(mrdata[0]), .grant_id_o(gid[0]), .busy_o(busy[0]),
        .timeout_o(tmo[0])
    );
    mem_arbiter_nch #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(TO)) u_fp (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
        .wen_i(wen[1]), .kill_i(kill[1]), .ack_o(ack[1]), .rdata_o(rdata[1]),
        .mem_req_o(mreq[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwdata[1]), .mem_wen_o(mwen[1]),
        .mem_ack_i(mack[1]), .mem_rdata_i(mrdata[1]), .grant_id_o(gid[1]), .busy_o(busy[1]),
        .timeout_o(tmo[1])
    );
    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    task automatic model_reset(input int d);
        owner[d]   = -1;
        blk[d]     = -1;
        last[d]    = N - 1;
        drn[d]     = 1'b0;
        e_req[d]   = 1'b0;
        e_wen[d]   = 1'b0;
        e_addr[d]  = '0;
        e_wdata[d] = '0;
        e_gid[d]   = '0;
        e_ack[d]   = '0;
    endtask
    task automatic new_payload(input int d, input int k);
        addr[d][k*AW +: AW]  = $urandom;
        wdata[d][k*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        wen[d][k]            = 1'($urandom_range(1));
    endtask
    task automatic drive(input int d);
        for (int k = 0; k < N; k++) begin
            if (want[d][k] && $urandom_range(29) == 0) want[d][k] = 1'b0;
            if (!want[d][k] && $urandom_range(2) == 0) begin
                want[d][k] = 1'b1;
                new_payload(d, k);
            end
            kill[d][k] = $urandom_range(23) == 0;
        end
        req[d]    = want[d];
        mack[d]   = $urandom_range(pa) == 0;
        mrdata[d] = {$urandom, $urandom, $urandom, $urandom};
    endtask
    task automatic compare(input int d);
        logic [N-1:0]  ea;
        logic [DW-1:0] erd;
        logic          eto;
        ea  = '0;
        erd = '0;
        eto = 1'b0;
        if (owner[d] >= 0 && !drn[d] && !kill[d][owner[d]] && mack[d]) begin
            ea[owner[d]] = 1'b1;
            erd          = mrdata[d];
        end
        if (owner[d] >= 0 && drn[d] && !mack[d] && cyc - dstart[d] == TO - 1) eto = 1'b1;
        e_ack[d] = ea;
        check($sformatf("u%0d.mem_req", d), DW'(mreq[d]), DW'(e_req[d]));
        check($sformatf("u%0d.mem_addr", d), DW'(maddr[d]), DW'(e_addr[d]));
        check($sformatf("u%0d.mem_wdata", d), mwdata[d], e_wdata[d]);
        check($sformatf("u%0d.mem_wen", d), DW'(mwen[d]), DW'(e_wen[d]));
        check($sformatf("u%0d.grant_id", d), DW'(gid[d]), DW'(e_gid[d]));
        check($sformatf("u%0d.busy", d), DW'(busy[d]), DW'(owner[d] >= 0));
        check($sformatf("u%0d.ack", d), DW'(ack[d]), DW'(ea));
        check($sformatf("u%0d.rdata", d), rdata[d], erd);
        check($sformatf("u%0d.timeout", d), DW'(tmo[d]), DW'(eto));
    endtask
    task automatic step(input int d);
        bit fin;
        int w;
        fin = 1'b0;
        w   = -1;
        want[d] &= ~(e_ack[d] | kill[d]);
        if (owner[d] >= 0) begin
            if (!drn[d]) begin
                if (kill[d][owner[d]]) begin
                    if (mack[d]) fin = 1'b1;
                    else begin
                        drn[d]    = 1'b1;
                        dstart[d] = cyc + 1;
                    end
                end else if (mack[d]) fin = 1'b1;
            end else if (mack[d] || cyc - dstart[d] == TO - 1) fin = 1'b1;
            if (fin) begin
                blk[d]   = owner[d];
                owner[d] = -1;
                drn[d]   = 1'b0;
                e_req[d] = 1'b0;
            end
        end else begin
            for (int j = 1; j <= N; j++) begin
                int c;
                c = (d == 0) ? (last[d] + j) % N : j - 1;
                if (w < 0 && req[d][c] && c != blk[d]) w = c;
            end
            blk[d] = -1;
            if (w >= 0) begin
                owner[d]   = w;
                last[d]    = w;
                e_gid[d]   = 2'(w);
                e_req[d]   = 1'b1;
                e_addr[d]  = addr[d][w*AW +: AW];
                e_wdata[d] = wdata[d][w*DW +: DW];
                e_wen[d]   = wen[d][w];
            end
        end
    endtask
    task automatic reset_seq();
        @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            want[d] = '1;
            req[d]  = '1;
            kill[d] = '0;
            mack[d] = 1'b0;
            for (int k = 0; k < N; k++) new_payload(d, k);
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("u%0d.rst_mem_req", d), DW'(mreq[d]), '0);
            check($sformatf("u%0d.rst_mem_addr", d), DW'(maddr[d]), '0);
            check($sformatf("u%0d.rst_mem_wdata", d), mwdata[d], '0);
            check($sformatf("u%0d.rst_grant_id", d), DW'(gid[d]), '0);
            check($sformatf("u%0d.rst_busy", d), DW'(busy[d]), '0);
            check($sformatf("u%0d.rst_ack", d), DW'(ack[d]), '0);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_reset(d);
    endtask
    initial begin
        for (int d = 0; d < 2; d++) begin
            want[d]   = '0;
            req[d]    = '0;
            kill[d]   = '0;
            wen[d]    = '0;
            addr[d]   = '0;
            wdata[d]  = '0;
            mack[d]   = 1'b0;
            mrdata[d] = '0;
            model_reset(d);
        end
        reset_seq();
        for (int i = 0; i < 3000; i++) begin
            pa = (i < 1500) ? 3 : 39;
            if (i == 1000) reset_seq();
            @(negedge clk);
            rst = 1'b0;
            drive(0);
            drive(1);
            #1;
            compare(0);
            compare(1);
            @(posedge clk);
            step(0);
            step(1);
            cyc++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
